// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// Latency: n/a (types only).
// Backpressure: n/a.
package dmem_arb_pkg;

    localparam int ADDR_W_DEF   = 8;
    localparam int DATA_W_DEF   = 32;
    localparam int MAX_WAIT_DEF = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_HOST = 2'd2
    } owner_e;

endpackage

// File: rtl/dmem_rd_return.sv
// Routes memory read data back to the port that issued the read.
// Latency: rd strobe in T, owner's rvalid pulse and new rdata in T+2.
// Backpressure: none; owners must accept the one-cycle rvalid pulse.
module dmem_rd_return
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  owner_e            rd_owner,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata
);

    owner_e owner_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= rd_owner;
        end
    end

    // mem_rdata is valid the cycle after the strobe, i.e. while owner_q holds the tag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_rvalid  <= 1'b0;
            host_rvalid <= 1'b0;
            cpu_rdata   <= '0;
            host_rdata  <= '0;
        end else begin
            cpu_rvalid  <= (owner_q == OWN_CPU);
            host_rvalid <= (owner_q == OWN_HOST);
            if (owner_q == OWN_CPU) begin
                cpu_rdata <= mem_rdata;
            end
            if (owner_q == OWN_HOST) begin
                host_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// CPU-priority arbiter for the single-port data memory with bounded host starvation.
// Latency: grant is combinational in the request cycle; read data returns two cycles later.
// Backpressure: a losing requester holds req until granted; cpu_stall flags the CPU wait.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cpu_stall
);

    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    logic [3:0] wait_cnt;
    logic       cpu_win;
    logic       host_win;
    owner_e     rd_owner;

    // reset gates the grants so nothing reaches the memory while rst is low
    always_comb begin
        cpu_win  = 1'b0;
        host_win = 1'b0;
        if (rst) begin
            if (cpu_req && host_req) begin
                if (wait_cnt >= WAIT_MAX) begin
                    host_win = 1'b1;
                end else begin
                    cpu_win = 1'b1;
                end
            end else if (cpu_req) begin
                cpu_win = 1'b1;
            end else if (host_req) begin
                host_win = 1'b1;
            end
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        rd_owner  = OWN_NONE;
        if (cpu_win) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_wr_en = cpu_we;
            mem_rd_en = ~cpu_we;
            rd_owner  = cpu_we ? OWN_NONE : OWN_CPU;
        end else if (host_win) begin
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
            mem_wr_en = host_we;
            mem_rd_en = ~host_we;
            rd_owner  = host_we ? OWN_NONE : OWN_HOST;
        end
    end

    assign cpu_gnt   = cpu_win;
    assign host_gnt  = host_win;
    assign cpu_stall = cpu_req & ~cpu_win;

    // counts consecutive arbitrations the host lost to the CPU
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= 4'd0;
        end else if (host_req && cpu_win) begin
            if (wait_cnt < WAIT_MAX) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
        end else begin
            wait_cnt <= 4'd0;
        end
    end

    dmem_rd_return #(
        .DATA_W(DATA_W)
    ) u_rd_return (
        .clk        (clk),
        .rst        (rst),
        .rd_owner   (rd_owner),
        .mem_rdata  (mem_rdata),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .host_rvalid(host_rvalid),
        .host_rdata (host_rdata)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and randomized bench for dmem_arbiter with a transaction-level reference model.
module tb_dmem_arbiter;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_we, host_req, host_we;
    logic [AW-1:0] cpu_addr, host_addr;
    logic [DW-1:0] cpu_wdata, host_wdata;
    logic          cpu_gnt, cpu_rvalid, host_gnt, host_rvalid, cpu_stall;
    logic [DW-1:0] cpu_rdata, host_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_rd_en, mem_wr_en;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd_en(mem_rd_en),
        .mem_wr_en(mem_wr_en), .mem_rdata(mem_rdata), .cpu_stall(cpu_stall)
    );

    always #5 clk = ~clk;

    // Memory behaviour: commit writes on the falling edge, registered read data.
    logic [DW-1:0] mem [256];
    always @(negedge clk) if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

    // Reference model state: transaction view of the memory and pending returns.
    typedef struct {
        bit            to_host;
        logic [DW-1:0] data;
        int            due;
    } ret_t;

    ret_t          rq[$];
    logic [DW-1:0] ref_mem [256];
    int            host_losses = 0;
    logic [DW-1:0] exp_crd = '0, exp_hrd = '0;
    int            ncomp = 0, nfail = 0, cyc = 0;
    bit            e_cgnt, e_hgnt;
    logic          s_cgnt, s_hgnt, s_crv, s_hrv;
    logic [DW-1:0] s_crd, s_hrd;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s cyc=%0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    // Samples mid-cycle, compares against the model, then advances to the next drive point.
    task automatic tick();
        bit            ecrv, ehrv;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        @(negedge clk);
        s_cgnt = cpu_gnt; s_hgnt = host_gnt; s_crv = cpu_rvalid; s_hrv = host_rvalid;
        s_crd = cpu_rdata; s_hrd = host_rdata;
        e_cgnt = 1'b0; e_hgnt = 1'b0; ecrv = 1'b0; ehrv = 1'b0;
        if (!rst) begin
            rq.delete();
            host_losses = 0;
            exp_crd = '0;
            exp_hrd = '0;
        end else begin
            e_hgnt = host_req && (!cpu_req || host_losses >= MW);
            e_cgnt = cpu_req && !e_hgnt;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                if (rq[0].to_host) begin ehrv = 1'b1; exp_hrd = rq[0].data; end
                else begin ecrv = 1'b1; exp_crd = rq[0].data; end
                void'(rq.pop_front());
            end
        end
        ea = e_cgnt ? cpu_addr : (e_hgnt ? host_addr : '0);
        ed = e_cgnt ? cpu_wdata : (e_hgnt ? host_wdata : '0);
        chk("cpu_gnt", cpu_gnt, e_cgnt);
        chk("host_gnt", host_gnt, e_hgnt);
        chk("cpu_stall", cpu_stall, cpu_req && !e_cgnt);
        chk("mem_wr_en", mem_wr_en, (e_cgnt && cpu_we) || (e_hgnt && host_we));
        chk("mem_rd_en", mem_rd_en, (e_cgnt && !cpu_we) || (e_hgnt && !host_we));
        chk("mem_addr", mem_addr, ea);
        chk("mem_wdata", mem_wdata, ed);
        chk("cpu_rvalid", cpu_rvalid, ecrv);
        chk("host_rvalid", host_rvalid, ehrv);
        chk("cpu_rdata", cpu_rdata, exp_crd);
        chk("host_rdata", host_rdata, exp_hrd);
        if (e_cgnt) begin
            host_losses = host_req ? host_losses + 1 : 0;
            if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
            else rq.push_back('{1'b0, ref_mem[cpu_addr], cyc + 2});
        end else begin
            host_losses = 0;
            if (e_hgnt) begin
                if (host_we) ref_mem[host_addr] = host_wdata;
                else rq.push_back('{1'b1, ref_mem[host_addr], cyc + 2});
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic set_cpu(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic set_host(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        host_req = r; host_we = w; host_addr = a; host_wdata = d;
    endtask

    task automatic idle();
        set_cpu(1'b0, 1'b0, '0, '0);
        set_host(1'b0, 1'b0, '0, '0);
    endtask

    bit c_pend, h_pend;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end
        rst = 1'b0;
        idle();
        @(posedge clk);
        #1;

        // Reset values, then CPU wins the first cycle after release
        set_cpu(1'b1, 1'b0, 8'h10, '0);
        set_host(1'b1, 1'b0, 8'h11, '0);
        tick();
        tick();
        chk("rst_hold_cpu_gnt", s_cgnt, 1'b0);
        chk("rst_hold_host_gnt", s_hgnt, 1'b0);
        rst = 1'b1;
        tick();
        chk("rel_cpu_first", s_cgnt, 1'b1);
        idle();
        repeat (3) tick();

        // Host write then CPU read of the same word
        set_host(1'b1, 1'b1, 8'h05, 32'h0000_0034);
        tick();
        chk("t2_host_wr_gnt", s_hgnt, 1'b1);
        idle();
        set_cpu(1'b1, 1'b0, 8'h05, '0);
        tick();
        chk("t2_cpu_rd_gnt", s_cgnt, 1'b1);
        idle();
        tick();
        chk("t2_no_early_rvalid", s_crv, 1'b0);
        tick();
        chk("t2_cpu_rvalid", s_crv, 1'b1);
        chk("t2_cpu_rdata", s_crd, 32'h0000_0034);
        chk("t2_host_rvalid", s_hrv, 1'b0);

        // Starvation bound: host forced in every fifth cycle
        for (int i = 0; i < 10; i++) begin
            set_cpu(1'b1, 1'b0, 8'(i), '0);
            set_host(1'b1, 1'b0, 8'(i + 32), '0);
            tick();
            chk("t3_host_slot", s_hgnt, (i % 5) == 4);
        end
        idle();
        repeat (3) tick();

        // Store then load of the same address back to back
        set_cpu(1'b1, 1'b1, 8'h02, 32'h1234_5678);
        tick();
        set_cpu(1'b1, 1'b0, 8'h02, '0);
        tick();
        idle();
        tick();
        tick();
        chk("t4_cpu_rvalid", s_crv, 1'b1);
        chk("t4_cpu_rdata", s_crd, 32'h1234_5678);

        // Interleaved host and CPU reads return in order
        set_host(1'b1, 1'b1, 8'h03, 32'hA5A5_0003);
        tick();
        idle();
        set_cpu(1'b1, 1'b1, 8'h04, 32'h0000_C004);
        tick();
        idle();
        set_host(1'b1, 1'b0, 8'h03, '0);
        tick();
        idle();
        set_cpu(1'b1, 1'b0, 8'h04, '0);
        tick();
        idle();
        tick();
        chk("t5_host_rvalid", s_hrv, 1'b1);
        chk("t5_host_rdata", s_hrd, 32'hA5A5_0003);
        chk("t5_cpu_not_yet", s_crv, 1'b0);
        tick();
        chk("t5_cpu_rvalid", s_crv, 1'b1);
        chk("t5_cpu_rdata", s_crd, 32'h0000_C004);
        chk("t5_host_done", s_hrv, 1'b0);

        // Reset during an in-flight CPU read
        set_cpu(1'b1, 1'b0, 8'h05, '0);
        tick();
        idle();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_no_rvalid", s_crv, 1'b0);
        end
        chk("t6_cpu_rdata_cleared", s_crd, '0);

        // Randomized traffic with held requests and occasional resets
        c_pend = 1'b0;
        h_pend = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!c_pend) begin
                if ($urandom_range(3) != 0) begin
                    set_cpu(1'b1, 1'($urandom), 8'($urandom_range(7)), $urandom);
                    c_pend = 1'b1;
                end else begin
                    set_cpu(1'b0, 1'b0, '0, '0);
                end
            end
            if (!h_pend) begin
                if ($urandom_range(2) != 0) begin
                    set_host(1'b1, 1'($urandom), 8'($urandom_range(7)), $urandom);
                    h_pend = 1'b1;
                end else begin
                    set_host(1'b0, 1'b0, '0, '0);
                end
            end
            rst = ($urandom_range(499) != 0);
            tick();
            if (e_cgnt) c_pend = 1'b0;
            if (e_hgnt) h_pend = 1'b0;
        end
        rst = 1'b1;
        idle();
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
